keccak_padder: RTL and testbench
================================

Name: keccak_padder

Overview:
- Upstream absorb stage of the SHA-3 core. Accepts the message as a stream of 32-bit words and packs 18 words into one 576-bit rate block.
- Applies Keccak pad10*1 padding to the final word and block.
- Presents each finished block to the permutation stage through an out_ready / f_ack handshake.
- Handles one message per reset.

Parameters:
- RATE_BITS, 576, block width delivered to the permutation stage.
- WORD_BITS, 32, input word width.
- WORDS_PER_BLOCK, 18, RATE_BITS/WORD_BITS.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in  input  32  message word; first byte in in[31:24].
- in_ready  input  1  in/is_last/byte_num valid this cycle.
- is_last  input  1  current word is the final (partial) word.
- byte_num  input  2  valid bytes in final word, 0..3; only meaningful with is_last.
- buffer_full  output  1  input not accepted this cycle.
- out  output  576  packed block; first word in out[575:544].
- out_ready  output  1  out holds a complete block.
- f_ack  input  1  permutation stage consumed out this cycle.
- msg_done  output  1  final block handed off; sticky until reset.

Behaviour:
- Reset values: all outputs 0, state FILL, word count cnt=0, final flag 0. Reset mid-operation discards any partial block.
- States:
  - FILL: accept words.
  - PAD: insert padding words.
  - FULL: block waiting for ack.
  - DONE: message complete.
- buffer_full = (state != FILL). It is combinational from state only.
- Accept condition: accept = in_ready & (state == FILL). Words presented while buffer_full=1 are ignored, not queued. The source must hold them.
- Shift rule: out <= {out[543:0], w}, cnt <= cnt+1. The word appears in out one cycle after accept.
- FILL, non-last word: w = in. If cnt==17, go to FULL, set out_ready=1, cnt=0.
- FILL, last word: w = pad1(in, byte_num), set final flag.
  - byte_num 0 -> 0x01000000; in is ignored.
  - byte_num 1 -> {in[31:24], 0x010000}.
  - byte_num 2 -> {in[31:16], 0x0100}.
  - byte_num 3 -> {in[31:8], 0x01}.
  - If cnt==17, also OR 0x00000080 into w and go to FULL. Otherwise go to PAD.
- PAD: one word per cycle, no input accepted.
  - cnt<17: w = 0.
  - cnt==17: w = 0x00000080, then go to FULL with out_ready=1.
- FULL: out and out_ready are held stable until f_ack.
  - On f_ack with final flag clear: go to FILL, out_ready=0 next cycle. The first new word is accepted the cycle after the ack, never in the ack cycle.
  - On f_ack with final flag set: go to DONE, out_ready=0, msg_done=1.
- f_ack outside FULL is ignored.
- DONE: buffer_full=1 and in_ready is ignored until reset.
- is_last without in_ready has no effect.
- If a message ends exactly on a block boundary, the source sends one extra word with is_last=1, byte_num=0. This produces an all-padding block: 0x01000000, 16 zero words, 0x00000080.
- Latency: for a last word at position p, out_ready asserts (17-p) cycles after the accept cycle, plus one register cycle.
- Throughput: 18 cycles per block plus one ack/turnaround cycle.

Decomposition:
- Shared package holds:
  - RATE_BITS, WORD_BITS and WORDS_PER_BLOCK constants.
  - The state enum {FILL, PAD, FULL, DONE}.
  - Padding constants: PAD_FIRST = 0x01, PAD_LAST = 0x80.
- One combinational sub-module, keccak_word_pad. It takes (in, byte_num, last_in_block) and returns the padded 32-bit word.
- The counter, state machine and block shift register live in keccak_padder.

Test Plan:
- Empty message: first word is_last=1, byte_num=0. Then:
  - out_ready=1 after 18 cycles.
  - out[575:544]=0x01000000, out[543:32]=0, out[31:0]=0x00000080.
  - f_ack gives msg_done=1 and out_ready=0.
- "abc": in=0x61626300, is_last=1, byte_num=3 -> out[575:544]=0x61626301, out[31:0]=0x00000080.
- 18 full words 0x00000000..0x00000011:
  - out_ready=1 and buffer_full=1.
  - in_ready during FULL is ignored and out is unchanged.
  - f_ack gives out_ready=0 and buffer_full=0 next cycle.
  - Then is_last, byte_num=0 produces an all-padding second block.
- 17 words then is_last=1, byte_num=3, in=0xAABBCC00 -> single block with out[31:0]=0xAABBCC81 and no PAD state visited.
- Last word at position 17, byte_num=0 -> out[31:0]=0x01000080.
- Reset asserted during PAD -> next cycle out_ready=0, buffer_full=0, out=0. A new message then packs from word 0.

Source files
------------

// File: rtl/keccak_padder_pkg.sv
// Shared constants for the SHA-3 absorb padder: block geometry, FSM codes, pad bytes.
// Latency: n/a (package).
// Backpressure: n/a (package).
package keccak_padder_pkg;

   localparam int RATE_BITS       = 576;
   localparam int WORD_BITS       = 32;
   localparam int WORDS_PER_BLOCK = RATE_BITS / WORD_BITS;
   localparam int CNT_BITS        = 5;

   // Index of the last word slot in a rate block
   localparam logic [CNT_BITS-1:0] LAST_WORD_IDX = CNT_BITS'(WORDS_PER_BLOCK - 1);

   // FSM state codes
   localparam logic [1:0] FILL = 2'd0;
   localparam logic [1:0] PAD  = 2'd1;
   localparam logic [1:0] FULL = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   // pad10*1 delimiter bytes: leading 1 after the message, trailing 1 at block end
   localparam logic [7:0] PAD_FIRST = 8'h01;
   localparam logic [7:0] PAD_LAST  = 8'h80;

endpackage

// File: rtl/keccak_word_pad.sv
// Applies pad10*1 to the final message word; adds the closing bit if it fills the block.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module keccak_word_pad
   import keccak_padder_pkg::*;
(
   input  logic [WORD_BITS-1:0] word_i,
   input  logic [1:0]           byte_num_i,
   input  logic                 last_in_block_i,
   output logic [WORD_BITS-1:0] word_o
);

   logic [WORD_BITS-1:0] keep_mask;
   logic [WORD_BITS-1:0] first_bit;

   // Keep the valid leading bytes, place the 0x01 delimiter right after them,
   // and OR in 0x80 when this word also closes the rate block.
   always_comb begin
      keep_mask = '0;
      first_bit = '0;
      case (byte_num_i)
         2'd0: begin keep_mask = 32'h0000_0000; first_bit = {PAD_FIRST, 24'h0}; end
         2'd1: begin keep_mask = 32'hFF00_0000; first_bit = {8'h0, PAD_FIRST, 16'h0}; end
         2'd2: begin keep_mask = 32'hFFFF_0000; first_bit = {16'h0, PAD_FIRST, 8'h0}; end
         default: begin keep_mask = 32'hFFFF_FF00; first_bit = {24'h0, PAD_FIRST}; end
      endcase
      word_o = (word_i & keep_mask) | first_bit;
      if (last_in_block_i) begin
         word_o = word_o | {24'h0, PAD_LAST};
      end
   end

endmodule

// File: rtl/keccak_padder.sv
// Packs 32-bit message words into 576-bit rate blocks and applies pad10*1 padding.
// Latency: word visible in out one cycle after accept; out_ready after the 18th word.
// Backpressure: buffer_full high outside FILL; held words are not queued, source holds them.
module keccak_padder
   import keccak_padder_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_BITS-1:0] in,
   input  logic                 in_ready,
   input  logic                 is_last,
   input  logic [1:0]           byte_num,
   output logic                 buffer_full,
   output logic [RATE_BITS-1:0] out,
   output logic                 out_ready,
   input  logic                 f_ack,
   output logic                 msg_done
);

   logic [1:0]           state_q,     state_d;
   logic [CNT_BITS-1:0]  cnt_q,       cnt_d;
   logic [RATE_BITS-1:0] out_q,       out_d;
   logic                 out_ready_q, out_ready_d;
   logic                 final_q,     final_d;
   logic                 msg_done_q,  msg_done_d;

   logic                 last_slot;
   logic                 shift_en;
   logic [WORD_BITS-1:0] shift_word;
   logic [WORD_BITS-1:0] padded_word;

   assign last_slot   = (cnt_q == LAST_WORD_IDX);
   assign buffer_full = (state_q != FILL);
   assign out         = out_q;
   assign out_ready   = out_ready_q;
   assign msg_done    = msg_done_q;

   keccak_word_pad u_word_pad (
      .word_i          (in),
      .byte_num_i      (byte_num),
      .last_in_block_i (last_slot),
      .word_o          (padded_word)
   );

   // Next-state logic: word selection, slot counter and block handshake.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_ready_d = out_ready_q;
      final_d     = final_q;
      msg_done_d  = msg_done_q;
      shift_en    = 1'b0;
      shift_word  = '0;

      case (state_q)
         FILL: begin
            if (in_ready) begin
               shift_en = 1'b1;
               if (is_last) begin
                  shift_word = padded_word;
                  final_d    = 1'b1;
               end else begin
                  shift_word = in;
               end
               if (last_slot) begin
                  state_d     = FULL;
                  out_ready_d = 1'b1;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (is_last) begin
                     state_d = PAD;
                  end
               end
            end
         end
         PAD: begin
            shift_en = 1'b1;
            if (last_slot) begin
               shift_word  = {24'h0, PAD_LAST};
               state_d     = FULL;
               out_ready_d = 1'b1;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FULL: begin
            if (f_ack) begin
               out_ready_d = 1'b0;
               if (final_q) begin
                  state_d    = DONE;
                  msg_done_d = 1'b1;
               end else begin
                  state_d = FILL;
               end
            end
         end
         default: begin
            // DONE: ignore everything until reset
         end
      endcase

      out_d = shift_en ? {out_q[RATE_BITS-WORD_BITS-1:0], shift_word} : out_q;
   end

   // State registers with synchronous active-high reset; reset drops any partial block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         out_q       <= '0;
         out_ready_q <= 1'b0;
         final_q     <= 1'b0;
         msg_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_ready_q <= out_ready_d;
         final_q     <= final_d;
         msg_done_q  <= msg_done_d;
      end
   end

endmodule

// File: tb/tb_keccak_padder.sv
// Randomised and directed bench for keccak_padder against a byte-level pad10*1 model.
// Latency: n/a.
// Backpressure: honours buffer_full; acks every block as soon as out_ready is seen.
module tb_keccak_padder;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  din;
   logic         in_ready;
   logic         is_last;
   logic [1:0]   byte_num;
   logic         buffer_full;
   logic [575:0] dout;
   logic         out_ready;
   logic         f_ack;
   logic         msg_done;

   int checks = 0;
   int errors = 0;

   logic [7:0]   msg_q[$];
   logic [575:0] exp_q[$];
   logic [575:0] got_q[$];
   int           lat;
   bit           timed_out;

   keccak_padder dut (
      .clk         (clk),
      .reset       (reset),
      .in          (din),
      .in_ready    (in_ready),
      .is_last     (is_last),
      .byte_num    (byte_num),
      .buffer_full (buffer_full),
      .out         (dout),
      .out_ready   (out_ready),
      .f_ack       (f_ack),
      .msg_done    (msg_done)
   );

   always #5 clk = ~clk;

   // Reference: message bytes, append 0x01, zero-fill to 72-byte multiple, OR 0x80 into last byte.
   task automatic build_expected();
      logic [7:0]   p[$];
      logic [575:0] blk;
      p = msg_q;
      p.push_back(8'h01);
      while (p.size() % 72 != 0) p.push_back(8'h00);
      p[p.size()-1] = p[p.size()-1] | 8'h80;
      exp_q.delete();
      for (int k = 0; k < p.size() / 72; k++) begin
         blk = '0;
         for (int i = 0; i < 72; i++) blk[575-8*i -: 8] = p[72*k+i];
         exp_q.push_back(blk);
      end
   endtask

   task automatic clear_inputs();
      din = '0; in_ready = 0; is_last = 0; byte_num = 0; f_ack = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      reset = 1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic rand_msg(input int len);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
   endtask

   // Streams msg_q into the DUT, acks every block, records blocks and final-word latency.
   task automatic run_message();
      int len    = msg_q.size();
      int nwords = len / 4 + 1;
      int widx   = 0;
      int cyc    = 0;
      int acc    = -1;
      bit seen   = 0;
      int idx;
      got_q.delete();
      lat = -1;
      timed_out = 0;
      forever begin
         @(negedge clk);
         if (acc >= 0 && !seen && out_ready) begin lat = cyc - acc; seen = 1; end
         clear_inputs();
         if (msg_done) break;
         if (cyc > 5000) begin timed_out = 1; break; end
         if (out_ready) begin
            got_q.push_back(dout);
            f_ack = 1;
         end else if (widx < nwords && !buffer_full) begin
            for (int b = 0; b < 4; b++) begin
               idx = 4*widx + b;
               din[31-8*b -: 8] = (idx < len) ? msg_q[idx] : 8'($urandom);
            end
            in_ready = 1;
            if (widx == nwords - 1) begin
               is_last  = 1;
               byte_num = 2'(len % 4);
               acc      = cyc + 1;
            end
            widx++;
         end
         @(posedge clk);
         cyc++;
      end
      clear_inputs();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_ready !== 1'b0) begin errors++; $display("FAIL reset_out_ready got %b exp 0", out_ready); end
      checks++; if (buffer_full !== 1'b0) begin errors++; $display("FAIL reset_buffer_full got %b exp 0", buffer_full); end
      checks++; if (msg_done !== 1'b0) begin errors++; $display("FAIL reset_msg_done got %b exp 0", msg_done); end
      checks++; if (dout !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", dout); end
   endtask

   task automatic test_empty();
      logic [575:0] blk;
      do_reset();
      msg_q.delete();
      build_expected();
      run_message();
      blk = (got_q.size() > 0) ? got_q[0] : '0;
      checks++; if (timed_out) begin errors++; $display("FAIL empty_timeout got 1 exp 0"); end
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL empty_blocks got %0d exp 1", got_q.size()); end
      checks++; if (blk[575:544] !== 32'h0100_0000) begin errors++; $display("FAIL empty_first got %h exp 01000000", blk[575:544]); end
      checks++; if (blk[543:32] !== '0) begin errors++; $display("FAIL empty_middle got %h exp 0", blk[543:32]); end
      checks++; if (blk[31:0] !== 32'h0000_0080) begin errors++; $display("FAIL empty_last got %h exp 00000080", blk[31:0]); end
      checks++; if (lat != 17) begin errors++; $display("FAIL empty_latency got %0d exp 17", lat); end
      checks++; if (msg_done !== 1'b1 || out_ready !== 1'b0) begin errors++; $display("FAIL empty_done got done=%b rdy=%b exp 1/0", msg_done, out_ready); end
   endtask

   task automatic test_abc();
      logic [575:0] blk;
      do_reset();
      msg_q = '{8'h61, 8'h62, 8'h63};
      build_expected();
      run_message();
      blk = (got_q.size() > 0) ? got_q[0] : '0;
      checks++; if (blk[575:544] !== 32'h6162_6301) begin errors++; $display("FAIL abc_first got %h exp 61626301", blk[575:544]); end
      checks++; if (blk[31:0] !== 32'h0000_0080) begin errors++; $display("FAIL abc_last got %h exp 00000080", blk[31:0]); end
      checks++; if (blk !== exp_q[0]) begin errors++; $display("FAIL abc_block got %h exp %h", blk, exp_q[0]); end
   endtask

   task automatic test_full_hold();
      logic [575:0] held;
      int           n;
      do_reset();
      msg_q.delete();
      for (int i = 0; i < 18; i++) begin
         msg_q.push_back(8'h00); msg_q.push_back(8'h00); msg_q.push_back(8'h00); msg_q.push_back(8'(i));
      end
      build_expected();
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         din = 32'(i); in_ready = 1;
         @(posedge clk);
      end
      @(negedge clk);
      clear_inputs();
      checks++; if (out_ready !== 1'b1 || buffer_full !== 1'b1) begin errors++; $display("FAIL hold_full got rdy=%b bf=%b exp 1/1", out_ready, buffer_full); end
      checks++; if (dout !== exp_q[0]) begin errors++; $display("FAIL hold_block got %h exp %h", dout, exp_q[0]); end
      held = dout;
      for (int i = 0; i < 3; i++) begin
         din = $urandom; in_ready = 1; is_last = 1; byte_num = 2'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      clear_inputs();
      checks++; if (dout !== held || out_ready !== 1'b1) begin errors++; $display("FAIL hold_ignore got rdy=%b out=%h exp 1 %h", out_ready, dout, held); end
      f_ack = 1;
      @(posedge clk);
      @(negedge clk);
      f_ack = 0;
      checks++; if (out_ready !== 1'b0 || buffer_full !== 1'b0 || msg_done !== 1'b0) begin errors++; $display("FAIL hold_ack got rdy=%b bf=%b done=%b exp 0/0/0", out_ready, buffer_full, msg_done); end
      din = $urandom; in_ready = 1; is_last = 1; byte_num = 2'd0;
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
      n = 0;
      while (!out_ready && n < 40) begin @(posedge clk); @(negedge clk); n++; end
      checks++; if (!out_ready) begin errors++; $display("FAIL hold_pad_timeout got rdy=0 exp 1"); end
      checks++; if (dout !== exp_q[1]) begin errors++; $display("FAIL hold_pad_block got %h exp %h", dout, exp_q[1]); end
      f_ack = 1;
      @(posedge clk);
      @(negedge clk);
      f_ack = 0;
      checks++; if (msg_done !== 1'b1 || out_ready !== 1'b0) begin errors++; $display("FAIL hold_done got done=%b rdy=%b exp 1/0", msg_done, out_ready); end
   endtask

   task automatic test_last_slot_partial();
      logic [575:0] blk;
      do_reset();
      rand_msg(68);
      msg_q.push_back(8'hAA); msg_q.push_back(8'hBB); msg_q.push_back(8'hCC);
      build_expected();
      run_message();
      blk = (got_q.size() > 0) ? got_q[0] : '0;
      checks++; if (blk[31:0] !== 32'hAABB_CC81) begin errors++; $display("FAIL slot17_b3 got %h exp aabbcc81", blk[31:0]); end
      checks++; if (lat != 0) begin errors++; $display("FAIL slot17_b3_latency got %0d exp 0", lat); end
      checks++; if (got_q.size() != 1 || blk !== exp_q[0]) begin errors++; $display("FAIL slot17_b3_block got %h exp %h", blk, exp_q[0]); end
   endtask

   task automatic test_last_slot_empty();
      logic [575:0] blk;
      do_reset();
      rand_msg(68);
      build_expected();
      run_message();
      blk = (got_q.size() > 0) ? got_q[0] : '0;
      checks++; if (blk[31:0] !== 32'h0100_0080) begin errors++; $display("FAIL slot17_b0 got %h exp 01000080", blk[31:0]); end
      checks++; if (blk !== exp_q[0]) begin errors++; $display("FAIL slot17_b0_block got %h exp %h", blk, exp_q[0]); end
   endtask

   task automatic test_reset_in_pad();
      logic [575:0] blk;
      do_reset();
      @(negedge clk);
      din = $urandom; in_ready = 1; is_last = 1; byte_num = 2'd1;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin @(negedge clk); clear_inputs(); @(posedge clk); end
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      checks++; if (out_ready !== 1'b0 || buffer_full !== 1'b0 || dout !== '0) begin errors++; $display("FAIL pad_reset got rdy=%b bf=%b out=%h exp 0/0/0", out_ready, buffer_full, dout); end
      rand_msg(10);
      build_expected();
      run_message();
      blk = (got_q.size() > 0) ? got_q[0] : '0;
      checks++; if (got_q.size() != 1 || blk !== exp_q[0]) begin errors++; $display("FAIL pad_reset_block got %h exp %h", blk, exp_q[0]); end
   endtask

   task automatic test_random();
      int len;
      for (int t = 0; t < 8; t++) begin
         do_reset();
         len = $urandom_range(0, 160);
         rand_msg(len);
         build_expected();
         run_message();
         checks++; if (timed_out) begin errors++; $display("FAIL rand_timeout len %0d got 1 exp 0", len); end
         checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count len %0d got %0d exp %0d", len, got_q.size(), exp_q.size()); end
         for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_block len %0d blk %0d got %h exp %h", len, k, got_q[k], exp_q[k]); end
         end
         checks++; if (lat != 17 - ((len / 4) % 18)) begin errors++; $display("FAIL rand_latency len %0d got %0d exp %0d", len, lat, 17 - ((len / 4) % 18)); end
         checks++; if (msg_done !== 1'b1) begin errors++; $display("FAIL rand_done len %0d got %b exp 1", len, msg_done); end
      end
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_empty();
      test_abc();
      test_full_hold();
      test_last_slot_partial();
      test_last_slot_empty();
      test_reset_in_pad();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
